muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 5, meaning destination-register tag width carried with each operation.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  abort any operation in flight.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  unit can accept a request.
REQ-008 SHALL have port op  input  3  RV32M funct3 encoding: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-009 SHALL have port a  input  XLEN  rs1 operand.
REQ-010 SHALL have port b  input  XLEN  rs2 operand.
REQ-011 SHALL have port tag_in  input  TAG_W  rd tag.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port result  output  XLEN  operation result.
REQ-015 SHALL have port tag_out  output  TAG_W  tag of the request that produced result.

Function
REQ-016 SHALL implement states IDLE, CALC, FIX, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 SHALL accept a request on a rising edge where in_valid && in_ready && !flush, registering op, operand magnitudes, sign flags and tag_in.
REQ-018 SHALL, on acceptance of a non-special operation, go IDLE->CALC and stay in CALC exactly XLEN cycles, one radix-2 step per cycle (shift-add multiply or restoring divide).
REQ-019 SHALL go CALC->FIX after the last step, apply sign correction and result selection in FIX, then go FIX->DONE; out_valid is first high XLEN+2 cycles after the accepting edge.
REQ-020 SHALL treat a as signed for mulh, mulhsu, div, rem; b as signed for mulh, div, rem; all others unsigned.
REQ-021 SHALL return low XLEN bits of the 2*XLEN product for mul, high XLEN bits for mulh/mulhsu/mulhu.
REQ-022 SHALL round quotient toward zero; remainder sign equals dividend sign.
REQ-023 SHALL detect divide-by-zero (b==0, op 1xx) at acceptance and go IDLE->DONE directly (out_valid one cycle after accept): div/divu result all ones, rem/remu result = a.
REQ-024 SHALL detect signed overflow (a = most negative, b = all ones, op div or rem) at acceptance and go IDLE->DONE directly: div result = a, rem result = 0.
REQ-025 SHALL hold result and tag_out stable in DONE until out_ready is sampled high, then go DONE->IDLE.
REQ-026 SHALL NOT accept a new request in the cycle DONE->IDLE occurs (in_ready low in DONE); back-to-back issue rate is one op per XLEN+3 cycles minimum.
REQ-027 SHALL, when flush is high on an edge, go to IDLE from any state, discarding the operation; flush has priority over acceptance and over out_ready in the same cycle.
REQ-028 SHALL ignore op/a/b/tag_in changes after acceptance.
REQ-029 SHALL produce results bit-identical to the RISC-V M-extension specification for all operand values at the configured XLEN.

Reset
REQ-030 SHALL, on reset high at a rising edge, enter IDLE from any state, abandoning any operation; reset has priority over flush and acceptance.
REQ-031 SHALL drive after reset: in_ready=1, out_valid=0, result=0, tag_out=0.

Verification
REQ-032 SHALL cover: XLEN=32, mul a=0x0000_0007 b=0xFFFF_FFFD tag=3 -> out_valid at accept+34, result=0xFFFF_FFEB, tag_out=3.
REQ-033 SHALL cover: mulh a=0x8000_0000 b=0x8000_0000 -> result=0x4000_0000; mulhu same operands -> 0x4000_0000; mulhsu a=0xFFFF_FFFF b=0xFFFF_FFFF -> 0xFFFF_FFFF.
REQ-034 SHALL cover: div a=-7 b=2 -> 0xFFFF_FFFD; rem -> 0xFFFF_FFFF; divu a=0x8000_0000 b=0 -> 0xFFFF_FFFF at accept+1; rem a=0x8000_0000 b=0xFFFF_FFFF -> 0 at accept+1.
REQ-035 SHALL cover: out_ready held low 10 cycles in DONE -> result/tag_out/out_valid stable; in_ready low throughout; in_valid pulsed there -> not accepted.
REQ-036 SHALL cover: flush at CALC cycle 5 -> IDLE next edge, no out_valid; flush coincident with in_valid in IDLE -> no acceptance; reset in FIX -> outputs at REQ-031 values next cycle.
REQ-037 SHALL cover: XLEN=64 random regression of 10,000 ops against a reference model, with random out_ready stalls, all results and tags matching.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// One radix-2 step per cycle works on operand magnitudes: shift-add for the
// multiply family and restoring division for the divide family. A final FIX
// cycle applies sign correction and selects the requested half or part.
// Divide-by-zero and signed overflow are resolved when the request is
// accepted and skip the iterative datapath entirely.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Architectural state
    state_t             state_q;
    logic [2:0]         op_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic [XLEN-1:0]    opnd_q;      // multiplicand (mul family) or divisor (div family)
    logic [2*XLEN-1:0]  work_q;      // {acc/remainder, multiplier/quotient}
    logic [CNT_W-1:0]   cnt_q;
    logic [TAG_W-1:0]   tag_q;

    // Registered outputs
    logic               in_ready_q;
    logic               out_valid_q;
    logic [XLEN-1:0]    result_q;
    logic [TAG_W-1:0]   tag_out_q;

    // Acceptance-time decode
    logic               acc_a_signed;
    logic               acc_b_signed;
    logic               acc_a_neg;
    logic               acc_b_neg;
    logic [XLEN-1:0]    acc_a_mag;
    logic [XLEN-1:0]    acc_b_mag;
    logic               acc_div_zero;
    logic               acc_div_ovf;
    logic               acc_special;
    logic [XLEN-1:0]    acc_special_res;
    logic [XLEN-1:0]    acc_opnd;
    logic [2*XLEN-1:0]  acc_work;

    // Iteration step
    logic [XLEN:0]      mul_addend;
    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  mul_next;
    logic [XLEN:0]      rem_shift;
    logic [XLEN+1:0]    div_diff;
    logic               div_ge;
    logic [XLEN-1:0]    rem_new;
    logic [2*XLEN-1:0]  div_next;
    logic [2*XLEN-1:0]  step_d;
    logic               div_unused;

    // Result fix-up
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quo_fix;
    logic [XLEN-1:0]    rem_fix;
    logic [XLEN-1:0]    fix_res_d;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign tag_out   = tag_out_q;

    // Decode the incoming request: signedness, magnitudes and special cases.
    always_comb begin
        acc_a_signed    = 1'b0;
        acc_b_signed    = 1'b0;
        acc_special_res = '0;
        case (op)
            OP_MULH:   begin acc_a_signed = 1'b1; acc_b_signed = 1'b1; end
            OP_MULHSU: begin acc_a_signed = 1'b1; acc_b_signed = 1'b0; end
            OP_DIV:    begin acc_a_signed = 1'b1; acc_b_signed = 1'b1; end
            OP_REM:    begin acc_a_signed = 1'b1; acc_b_signed = 1'b1; end
            default:   begin acc_a_signed = 1'b0; acc_b_signed = 1'b0; end
        endcase

        acc_a_neg = acc_a_signed & a[XLEN-1];
        acc_b_neg = acc_b_signed & b[XLEN-1];

        if (acc_a_neg) begin
            acc_a_mag = -a;
        end else begin
            acc_a_mag = a;
        end
        if (acc_b_neg) begin
            acc_b_mag = -b;
        end else begin
            acc_b_mag = b;
        end

        acc_div_zero = op[2] & (b == '0);
        acc_div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                       (a == MOST_NEG) && (b == '1);
        acc_special  = acc_div_zero | acc_div_ovf;

        // op[1] separates the remainder ops from the quotient ops
        if (acc_div_zero) begin
            if (op[1]) begin
                acc_special_res = a;
            end else begin
                acc_special_res = '1;
            end
        end else if (acc_div_ovf) begin
            if (op[1]) begin
                acc_special_res = '0;
            end else begin
                acc_special_res = a;
            end
        end else begin
            acc_special_res = '0;
        end

        // Multiply: multiplier sits in the low half, divide: dividend does.
        if (op[2]) begin
            acc_opnd = acc_b_mag;
            acc_work = {{XLEN{1'b0}}, acc_a_mag};
        end else begin
            acc_opnd = acc_a_mag;
            acc_work = {{XLEN{1'b0}}, acc_b_mag};
        end
    end

    // One radix-2 step: shift-add multiply or restoring divide.
    always_comb begin
        if (work_q[0]) begin
            mul_addend = {1'b0, opnd_q};
        end else begin
            mul_addend = '0;
        end
        mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + mul_addend;
        mul_next = {mul_sum, work_q[XLEN-1:1]};

        // The shifted partial remainder is always below twice the divisor,
        // so whichever value survives fits back into XLEN bits.
        rem_shift  = work_q[2*XLEN-1:XLEN-1];
        div_diff   = {1'b0, rem_shift} - {2'b00, opnd_q};
        div_ge     = ~div_diff[XLEN+1];
        div_unused = div_diff[XLEN];
        if (div_ge) begin
            rem_new = div_diff[XLEN-1:0];
        end else begin
            rem_new = rem_shift[XLEN-1:0];
        end
        div_next = {rem_new, work_q[XLEN-2:0], div_ge};

        if (op_q[2]) begin
            step_d = div_next;
        end else begin
            step_d = mul_next;
        end
    end

    // Sign correction and result selection applied in FIX.
    always_comb begin
        if (neg_a_q ^ neg_b_q) begin
            prod_fix = -work_q;
            quo_fix  = -work_q[XLEN-1:0];
        end else begin
            prod_fix = work_q;
            quo_fix  = work_q[XLEN-1:0];
        end
        // Remainder takes the sign of the dividend.
        if (neg_a_q) begin
            rem_fix = -work_q[2*XLEN-1:XLEN];
        end else begin
            rem_fix = work_q[2*XLEN-1:XLEN];
        end

        case (op_q)
            OP_MUL:    fix_res_d = prod_fix[XLEN-1:0];
            OP_MULH:   fix_res_d = prod_fix[2*XLEN-1:XLEN];
            OP_MULHSU: fix_res_d = prod_fix[2*XLEN-1:XLEN];
            OP_MULHU:  fix_res_d = prod_fix[2*XLEN-1:XLEN];
            OP_DIV:    fix_res_d = quo_fix;
            OP_DIVU:   fix_res_d = quo_fix;
            OP_REM:    fix_res_d = rem_fix;
            OP_REMU:   fix_res_d = rem_fix;
            default:   fix_res_d = '0;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 3'b000;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            opnd_q      <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            tag_out_q   <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q       <= op;
                        neg_a_q    <= acc_a_neg;
                        neg_b_q    <= acc_b_neg;
                        opnd_q     <= acc_opnd;
                        work_q     <= acc_work;
                        cnt_q      <= '0;
                        tag_q      <= tag_in;
                        in_ready_q <= 1'b0;
                        if (acc_special) begin
                            result_q    <= acc_special_res;
                            tag_out_q   <= tag_in;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    work_q <= step_d;
                    cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_STEP) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q    <= fix_res_d;
                    tag_out_q   <= tag_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
